// File: rtl/frame_scheduler_if.sv
// Handshake bundle between the frame scheduler and its environment.
// The slave modport is the scheduler's view; master is the driver/monitor view.
interface frame_scheduler_if;
  logic        vsync;
  logic        enable;
  logic        update_done;
  logic        err_clr;
  logic        update_start;
  logic        commit;
  logic        busy;
  logic        overrun;
  logic        timeout_err;
  logic [15:0] frame_cnt;

  modport master (
    output vsync, enable, update_done, err_clr,
    input  update_start, commit, busy, overrun, timeout_err, frame_cnt
  );

  modport slave (
    input  vsync, enable, update_done, err_clr,
    output update_start, commit, busy, overrun, timeout_err, frame_cnt
  );
endinterface

// File: rtl/frame_scheduler.sv
// Frame scheduler: turns vsync frame starts into periodic game-update
// requests, waits for completion and issues a one-cycle commit. Overruns
// (frame start while a sequence is in flight) and update timeouts are
// reported through sticky flags.
module frame_scheduler #(
  parameter bit          VSYNC_ACTIVE_LOW = 1'b1,
  parameter int unsigned FRAME_DIV        = 1,
  parameter int unsigned TIMEOUT_CYCLES   = 1000000
) (
  input  logic            clk,
  input  logic            rst,
  frame_scheduler_if.slave bus
);

  localparam int unsigned TW         = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMAX     = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]  DIV_RELOAD = 8'(FRAME_DIV - 1);
  localparam logic        INACT      = VSYNC_ACTIVE_LOW;

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_COMMIT} state_t;

  state_t        r_state, w_state_nxt;
  logic          r_sync1, r_sync2, r_sync3;
  logic [7:0]    r_div, w_div_nxt;
  logic [TW-1:0] r_timer, w_timer_nxt;
  logic [15:0]   r_frame_cnt, w_cnt_nxt;
  logic          r_overrun, r_timeout_err;
  logic          w_act_now, w_act_prev, w_frame_tick;
  logic          w_set_ovr, w_set_to;
  logic          w_update_start, w_commit, w_busy;

  // Synchronizer plus one history flop for edge detection, preset inactive.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= INACT;
      r_sync2 <= INACT;
      r_sync3 <= INACT;
    end else begin
      r_sync1 <= bus.vsync;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
    end
  end

  assign w_act_now    = r_sync2 ^ VSYNC_ACTIVE_LOW;
  assign w_act_prev   = r_sync3 ^ VSYNC_ACTIVE_LOW;
  assign w_frame_tick = w_act_now & ~w_act_prev;

  // State, divider, timer, counter and sticky error registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_div         <= DIV_RELOAD;
      r_timer       <= '0;
      r_frame_cnt   <= '0;
      r_overrun     <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_div         <= w_div_nxt;
      r_timer       <= w_timer_nxt;
      r_frame_cnt   <= w_cnt_nxt;
      r_overrun     <= w_set_ovr | (r_overrun & ~bus.err_clr);
      r_timeout_err <= w_set_to  | (r_timeout_err & ~bus.err_clr);
    end
  end

  // Next-state and Moore outputs; a tick outside IDLE is dropped as an overrun.
  always_comb begin
    w_state_nxt    = r_state;
    w_div_nxt      = r_div;
    w_timer_nxt    = r_timer;
    w_cnt_nxt      = r_frame_cnt;
    w_set_to       = 1'b0;
    w_update_start = 1'b0;
    w_commit       = 1'b0;
    w_busy         = 1'b0;
    w_set_ovr      = w_frame_tick & (r_state != S_IDLE);
    case (r_state)
      S_IDLE: begin
        if (w_frame_tick && bus.enable) begin
          if (r_div == '0) begin
            w_div_nxt   = DIV_RELOAD;
            w_state_nxt = S_START;
          end else begin
            w_div_nxt   = r_div - 8'd1;
          end
        end
      end
      S_START: begin
        w_update_start = 1'b1;
        w_busy         = 1'b1;
        w_timer_nxt    = '0;
        w_state_nxt    = S_WAIT;
      end
      S_WAIT: begin
        w_busy      = 1'b1;
        w_timer_nxt = r_timer + TW'(1);
        if (bus.update_done) begin
          w_state_nxt = S_COMMIT;
        end else if (r_timer == TMAX) begin
          w_set_to    = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_COMMIT: begin
        w_commit    = 1'b1;
        w_busy      = 1'b1;
        w_cnt_nxt   = r_frame_cnt + 16'd1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign bus.update_start = w_update_start;
  assign bus.commit       = w_commit;
  assign bus.busy         = w_busy;
  assign bus.overrun      = r_overrun;
  assign bus.timeout_err  = r_timeout_err;
  assign bus.frame_cnt    = r_frame_cnt;

endmodule
